alu_result_drain: RTL

//  Consumer end of the ALU result interface. Accepts the 64-bit OpResult plus its
//  12-bit one-hot ctrl_signal, and buffers it in a 2-entry Z queue. Drains each

---
 rtl/alu_result_drain_pkg.sv | 29 ++
 rtl/alu_result_drain_if.sv | 44 ++++
 rtl/alu_result_drain_z_queue.sv | 56 +++++
 rtl/alu_result_drain.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/alu_result_drain_pkg.sv
// Shared definitions for the ALU result path.
// Package alu_pkg: ctrl_signal bit positions, the Z queue entry layout and
// the drain FSM state type. Used by alu_result_drain, its interface and z_queue.
package alu_pkg;

  localparam int unsigned OP_ADD_BIT = 0;
  localparam int unsigned OP_AND_BIT = 8;
  localparam int unsigned OP_OR_BIT  = 9;
  localparam int unsigned OP_MUL_BIT = 10;
  localparam int unsigned OP_DIV_BIT = 11;
  localparam int unsigned CTRL_W     = 12;

  typedef struct packed {
    logic        wide;
    logic [63:0] result;
  } z_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } drain_state_t;

  // Only MUL/DIV produce a meaningful upper half; any other pattern is narrow.
  function automatic logic is_wide(input logic [CTRL_W-1:0] ctrl);
    return ctrl[OP_MUL_BIT] | ctrl[OP_DIV_BIT];
  endfunction

endpackage

// File: rtl/alu_result_drain_if.sv
// Result-in / beat-out signal bundle for alu_result_drain.
//   res_valid/res_ready/ctrl_signal/OpResult : ALU result handshake
//   bus_valid/bus_ready/bus_data/bus_hi      : 32-bit datapath beat handshake
//   busy                                     : queue non-empty or beat in flight
//   flag_z/flag_n                            : only with STATUS_FLAGS_EN defined
// modport slave is the drain itself, modport master the producer/bus side.
interface alu_result_drain_if #(
  parameter int unsigned BITS = 32
);
  import alu_pkg::*;

  logic                res_valid;
  logic                res_ready;
  logic [CTRL_W-1:0]   ctrl_signal;
  logic [2*BITS-1:0]   OpResult;
  logic                bus_valid;
  logic                bus_ready;
  logic [BITS-1:0]     bus_data;
  logic                bus_hi;
  logic                busy;
`ifdef STATUS_FLAGS_EN
  logic                flag_z;
  logic                flag_n;
`endif

  modport slave (
    input  res_valid, ctrl_signal, OpResult, bus_ready,
    output res_ready, bus_valid, bus_data, bus_hi,
`ifdef STATUS_FLAGS_EN
    output flag_z, flag_n,
`endif
    output busy
  );

  modport master (
    output res_valid, ctrl_signal, OpResult, bus_ready,
    input  res_ready, bus_valid, bus_data, bus_hi,
`ifdef STATUS_FLAGS_EN
    input  flag_z, flag_n,
`endif
    input  busy
  );

endinterface

// File: rtl/alu_result_drain_z_queue.sv
// z_queue: small synchronous FIFO holding pending Z entries.
//   clk, clr (async active-low) ; i_push/i_data write ; i_pop retires head
//   o_head  : oldest entry, o_next : entry behind it (valid when o_count > 1)
//   o_count : occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module z_queue #(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [W-1:0]             o_next,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && (r_count < CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_next  = r_mem[r_rd + AW'(1)];
  assign o_count = r_count;

endmodule

// File: rtl/alu_result_drain.sv
// alu_result_drain: buffers ALU results in a DEPTH-entry Z queue and drains
// each one onto the BITS-wide bus as ZLow, then ZHigh for MUL/DIV results.
//   clk : rising-edge clock     clr : asynchronous active-low reset
//   bus : alu_result_drain_if.slave (result handshake in, beat handshake out)
// Optional feature macro STATUS_FLAGS_EN adds per-entry flag_z/flag_n.
// All beat outputs are registered; res_ready and busy decode registered state.
module alu_result_drain
  import alu_pkg::*;
#(
  parameter int unsigned BITS  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  alu_result_drain_if.slave    bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned RW = 2 * BITS;
`ifdef STATUS_FLAGS_EN
  // Entry layout: {flag_z, flag_n, wide, result}
  localparam int unsigned EW = RW + 3;
`else
  // Entry layout: {wide, result}
  localparam int unsigned EW = RW + 1;
`endif

  logic [EW-1:0]  w_in;
  logic [EW-1:0]  w_head;
  logic [EW-1:0]  w_next;
  logic [EW-1:0]  w_src;
  logic [CW-1:0]  w_count;
  logic           w_res_ready;
  logic           w_push;
  logic           w_pop;
  logic           w_wide_in;

  drain_state_t   r_state;
  drain_state_t   w_state_nxt;
  logic           r_valid;
  logic           r_hi;
  logic [BITS-1:0] r_data;
  logic           w_valid_nxt;
  logic           w_hi_nxt;
  logic [BITS-1:0] w_data_nxt;

  assign w_res_ready = (w_count < CW'(DEPTH));
  assign w_push      = bus.res_valid & w_res_ready;
  assign w_wide_in   = is_wide(bus.ctrl_signal);

`ifdef STATUS_FLAGS_EN
  logic w_fz_in;
  logic w_fn_in;
  logic r_fz;
  logic r_fn;
  logic w_fz_nxt;
  logic w_fn_nxt;
  assign w_fz_in = (bus.OpResult == '0);
  assign w_fn_in = w_wide_in ? bus.OpResult[RW-1] : bus.OpResult[BITS-1];
  assign w_in    = {w_fz_in, w_fn_in, w_wide_in, bus.OpResult};
`else
  assign w_in    = {w_wide_in, bus.OpResult};
`endif

  z_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_z_queue (
    .clk     (clk),
    .clr     (clr),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_count)
  );

  // w_src is the entry the next beat comes from: after a pop that leaves
  // the queue non-empty, the registered beat must already show the entry
  // behind the current head, which is why the queue exposes o_next.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_src       = w_head;
    case (r_state)
      ST_IDLE: begin
        if (w_count != '0) w_state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (bus.bus_ready) begin
          if (w_head[RW]) begin
            w_state_nxt = ST_HIGH;
          end else begin
            w_pop       = 1'b1;
            w_src       = w_next;
            w_state_nxt = (w_count > CW'(1)) ? ST_LOW : ST_IDLE;
          end
        end
      end
      ST_HIGH: begin
        if (bus.bus_ready) begin
          w_pop       = 1'b1;
          w_src       = w_next;
          w_state_nxt = (w_count > CW'(1)) ? ST_LOW : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_valid_nxt = 1'b0;
    w_hi_nxt    = 1'b0;
    w_data_nxt  = '0;
    case (w_state_nxt)
      ST_LOW: begin
        w_valid_nxt = 1'b1;
        w_data_nxt  = w_src[BITS-1:0];
      end
      ST_HIGH: begin
        w_valid_nxt = 1'b1;
        w_hi_nxt    = 1'b1;
        w_data_nxt  = w_src[RW-1:BITS];
      end
      default: ;
    endcase
`ifdef STATUS_FLAGS_EN
    w_fz_nxt = w_valid_nxt & w_src[RW+2];
    w_fn_nxt = w_valid_nxt & w_src[RW+1];
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_hi    <= 1'b0;
      r_data  <= '0;
`ifdef STATUS_FLAGS_EN
      r_fz    <= 1'b0;
      r_fn    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_hi    <= w_hi_nxt;
      r_data  <= w_data_nxt;
`ifdef STATUS_FLAGS_EN
      r_fz    <= w_fz_nxt;
      r_fn    <= w_fn_nxt;
`endif
    end
  end

  assign bus.res_ready = w_res_ready;
  assign bus.bus_valid = r_valid;
  assign bus.bus_hi    = r_hi;
  assign bus.bus_data  = r_data;
  assign bus.busy      = (w_count != '0) | (r_state != ST_IDLE);
`ifdef STATUS_FLAGS_EN
  assign bus.flag_z    = r_fz;
  assign bus.flag_n    = r_fn;
`endif

endmodule
